// File: rtl/mem_port_arbiter_if.sv
// Bundle of the instruction-fetch port, data port, shared memory bus and stall
// requests seen by the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             i_if_req;
  logic [WIDTH-1:0] i_if_addr;
  logic [WIDTH-1:0] o_if_rdata;
  logic             o_if_valid;
  logic             o_if_err;

  logic             i_d_req;
  logic             i_d_we;
  logic [WIDTH-1:0] i_d_addr;
  logic [WIDTH-1:0] i_d_wdata;
  logic [3:0]       i_d_byteen;
  logic [WIDTH-1:0] o_d_rdata;
  logic             o_d_valid;
  logic             o_d_err;

  logic             o_mem_req;
  logic [WIDTH-1:0] o_mem_addr;
  logic [WIDTH-1:0] o_mem_write_data;
  logic [3:0]       o_mem_byteen;
  logic             o_mem_write_enable;
  logic             o_mem_read_enable;
  logic             i_mem_ready;
  logic [WIDTH-1:0] i_mem_read_data;

  logic             o_stall_if;
  logic             o_stall_mem;

  // The arbiter masters the shared bus; the environment (pipeline + memory) is the slave side.
  modport master (
    input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_byteen,
           i_mem_ready, i_mem_read_data,
    output o_if_rdata, o_if_valid, o_if_err, o_d_rdata, o_d_valid, o_d_err,
           o_mem_req, o_mem_addr, o_mem_write_data, o_mem_byteen,
           o_mem_write_enable, o_mem_read_enable, o_stall_if, o_stall_mem
  );

  modport slave (
    output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_byteen,
           i_mem_ready, i_mem_read_data,
    input  o_if_rdata, o_if_valid, o_if_err, o_d_rdata, o_d_valid, o_d_err,
           o_mem_req, o_mem_addr, o_mem_write_data, o_mem_byteen,
           o_mem_write_enable, o_mem_read_enable, o_stall_if, o_stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single memory bus between instruction fetch and data accesses,
// data first, with a per-transfer wait-state timeout that aborts with an error.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  mem_port_arbiter_if.master  bus
);
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WIDTH-1:0]  r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic [3:0]        r_byteen;
  logic              r_we;
  logic [WAIT_W-1:0] r_wait;
  logic [WIDTH-1:0]  r_if_rdata;
  logic              r_if_valid;
  logic              r_if_err;
  logic [WIDTH-1:0]  r_d_rdata;
  logic              r_d_valid;
  logic              r_d_err;

  logic w_busy;
  logic w_d_elig;
  logic w_if_elig;
  logic w_grant_d;
  logic w_grant_i;
  logic w_done;
  logic w_abort;

  // A requester is masked during its own valid cycle so a still-held request is not re-granted.
  assign w_d_elig  = bus.i_d_req  & ~r_d_valid;
  assign w_if_elig = bus.i_if_req & ~r_if_valid;
  assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);

  always_comb begin
    w_next_state = r_state;
    w_grant_d    = 1'b0;
    w_grant_i    = 1'b0;
    w_done       = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_d_elig) begin
          w_grant_d    = 1'b1;
          w_next_state = BUSY_D;
        end else if (w_if_elig) begin
          w_grant_i    = 1'b1;
          w_next_state = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (bus.i_mem_ready) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end else if (r_wait == WAIT_LAST) begin
          w_abort      = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next_state;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_byteen   <= '0;
      r_we       <= 1'b0;
      r_wait     <= '0;
      r_if_rdata <= '0;
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_rdata  <= '0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
    end else begin
      r_if_valid <= 1'b0;
      r_if_err   <= 1'b0;
      r_d_valid  <= 1'b0;
      r_d_err    <= 1'b0;
      if (w_grant_d) begin
        r_addr   <= bus.i_d_addr;
        r_wdata  <= bus.i_d_wdata;
        r_byteen <= bus.i_d_byteen;
        r_we     <= bus.i_d_we;
        r_wait   <= '0;
      end else if (w_grant_i) begin
        r_addr   <= bus.i_if_addr;
        r_wdata  <= '0;
        r_byteen <= 4'hF;
        r_we     <= 1'b0;
        r_wait   <= '0;
      end else if (w_busy && !w_done && !w_abort) begin
        r_wait   <= r_wait + WAIT_W'(1);
      end
      if (w_done) begin
        if (r_state == BUSY_I) begin
          r_if_rdata <= bus.i_mem_read_data;
          r_if_valid <= 1'b1;
        end else begin
          // Stores leave the last load result visible.
          if (!r_we) r_d_rdata <= bus.i_mem_read_data;
          r_d_valid <= 1'b1;
        end
      end else if (w_abort) begin
        if (r_state == BUSY_I) begin
          r_if_rdata <= '0;
          r_if_valid <= 1'b1;
          r_if_err   <= 1'b1;
        end else begin
          r_d_rdata  <= '0;
          r_d_valid  <= 1'b1;
          r_d_err    <= 1'b1;
        end
      end
    end
  end

  assign bus.o_mem_req          = w_busy;
  assign bus.o_mem_addr         = w_busy ? r_addr   : '0;
  assign bus.o_mem_write_data   = w_busy ? r_wdata  : '0;
  assign bus.o_mem_byteen       = w_busy ? r_byteen : '0;
  assign bus.o_mem_write_enable = w_busy &  r_we;
  assign bus.o_mem_read_enable  = w_busy & ~r_we;

  assign bus.o_if_rdata  = r_if_rdata;
  assign bus.o_if_valid  = r_if_valid;
  assign bus.o_if_err    = r_if_err;
  assign bus.o_d_rdata   = r_d_rdata;
  assign bus.o_d_valid   = r_d_valid;
  assign bus.o_d_err     = r_d_err;

  assign bus.o_stall_if  = bus.i_if_req & ~r_if_valid;
  assign bus.o_stall_mem = bus.i_d_req  & ~r_d_valid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: the bench plays pipeline and memory, keeps a
// word-addressed memory image, and predicts every transfer at transaction level.
module tb_mem_port_arbiter;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  logic [31:0] mem [int];
  logic [31:0] exp_if_rdata;
  logic [31:0] exp_d_rdata;

  mem_port_arbiter_if #(.WIDTH(32)) bus ();

  mem_port_arbiter #(.WIDTH(32), .TIMEOUT(TMO)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return a ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] bus_vec();
    return {57'd0, bus.o_mem_req, bus.o_mem_addr, bus.o_mem_write_data, bus.o_mem_byteen,
            bus.o_mem_write_enable, bus.o_mem_read_enable};
  endfunction

  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_bus0"}, bus_vec(), 128'd0);
    chk({tag, "_vld0"}, {bus.o_if_valid, bus.o_d_valid}, 0);
  endtask

  // Entered at the drive point of the first BUSY cycle; leaves at the negedge of the valid cycle.
  task automatic busy_phase(input bit is_d, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be,
                            input int waits, input bit tmo, input string tag);
    int          n;
    logic [31:0] rd;
    logic [127:0] exp_bus;
    bit          wr;
    wr = is_d && we;
    n  = tmo ? TMO : waits + 1;
    rd = wr ? $urandom : mem_rd(addr);
    exp_bus = {57'd0, 1'b1, addr, (is_d ? wdata : 32'd0), (is_d ? be : 4'hF), wr, ~wr};
    for (int k = 1; k <= n; k++) begin
      bus.i_mem_ready     = (!tmo && k == n);
      bus.i_mem_read_data = (!tmo && k == n) ? rd : $urandom;
      @(negedge clk);
      chk({tag, "_busbus"}, bus_vec(), exp_bus);
      chk({tag, "_busvld"}, {bus.o_if_valid, bus.o_d_valid}, 0);
      chk({tag, "_stall"}, is_d ? bus.o_stall_mem : bus.o_stall_if, 1);
      drive_point();
    end
    bus.i_mem_ready     = 1'($urandom);
    bus.i_mem_read_data = $urandom;
    if (tmo) begin
      if (is_d) exp_d_rdata = 32'd0; else exp_if_rdata = 32'd0;
    end else if (wr) begin
      mem[int'(addr)] = merge(mem_rd(addr), wdata, be);
    end else begin
      if (is_d) exp_d_rdata = rd; else exp_if_rdata = rd;
    end
    @(negedge clk);
    chk({tag, "_vld"}, {bus.o_if_valid, bus.o_d_valid}, is_d ? 2'b01 : 2'b10);
    chk({tag, "_err"}, is_d ? bus.o_d_err : bus.o_if_err, tmo);
    chk({tag, "_rdata"}, is_d ? bus.o_d_rdata : bus.o_if_rdata, is_d ? exp_d_rdata : exp_if_rdata);
    chk({tag, "_vbus0"}, bus_vec(), 128'd0);
    chk({tag, "_vstall"}, is_d ? bus.o_stall_mem : bus.o_stall_if, 0);
  endtask

  task automatic single(input bit is_d, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input int waits, input bit tmo, input string tag);
    drive_point();
    if (is_d) begin
      bus.i_d_req = 1'b1; bus.i_d_we = we; bus.i_d_addr = addr;
      bus.i_d_wdata = wdata; bus.i_d_byteen = be;
    end else begin
      bus.i_if_req = 1'b1; bus.i_if_addr = addr;
    end
    @(negedge clk);
    chk({tag, "_req"}, bus_vec(), 128'd0);
    chk({tag, "_rstall"}, is_d ? bus.o_stall_mem : bus.o_stall_if, 1);
    drive_point();
    busy_phase(is_d, we, addr, wdata, be, waits, tmo, tag);
    drive_point();
    bus.i_if_req = 1'b0; bus.i_d_req = 1'b0; bus.i_mem_ready = 1'b0;
    @(negedge clk);
    chk_idle({tag, "_after"});
  endtask

  task automatic collide(input logic [31:0] ia, input logic we, input logic [31:0] da,
                         input logic [31:0] dw, input logic [3:0] be,
                         input int dwaits, input bit dtmo, input int iwaits, input string tag);
    drive_point();
    bus.i_if_req = 1'b1; bus.i_if_addr = ia;
    bus.i_d_req = 1'b1; bus.i_d_we = we; bus.i_d_addr = da;
    bus.i_d_wdata = dw; bus.i_d_byteen = be;
    @(negedge clk);
    chk({tag, "_stalls"}, {bus.o_stall_if, bus.o_stall_mem}, 2'b11);
    drive_point();
    busy_phase(1'b1, we, da, dw, be, dwaits, dtmo, {tag, "_d"});
    chk({tag, "_ifwait"}, bus.o_stall_if, 1);
    drive_point();
    bus.i_d_req = 1'b0;
    busy_phase(1'b0, 1'b0, ia, 32'd0, 4'hF, iwaits, 1'b0, {tag, "_i"});
    drive_point();
    bus.i_if_req = 1'b0; bus.i_mem_ready = 1'b0;
    @(negedge clk);
    chk_idle({tag, "_after"});
  endtask

  initial begin
    logic [31:0] a, w;
    logic [3:0]  be;
    int          mode;
    rst = 1'b1;
    bus.i_if_req = 1'b0; bus.i_if_addr = '0;
    bus.i_d_req = 1'b0; bus.i_d_we = 1'b0; bus.i_d_addr = '0;
    bus.i_d_wdata = '0; bus.i_d_byteen = '0;
    bus.i_mem_ready = 1'b0; bus.i_mem_read_data = '0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    mem[32'h100] = 32'h0000_0013;
    mem[32'h3000] = 32'h1234_5678;

    repeat (2) drive_point();
    @(negedge clk);
    chk_idle("reset");
    chk("reset_rdata", {bus.o_if_rdata, bus.o_d_rdata}, 64'd0);
    chk("reset_err", {bus.o_if_err, bus.o_d_err}, 0);
    chk("reset_stall", {bus.o_stall_if, bus.o_stall_mem}, 0);
    drive_point();
    rst = 1'b0;

    single(1'b0, 1'b0, 32'h100, 32'd0, 4'hF, 0, 1'b0, "fetch");
    collide(32'h104, 1'b1, 32'h2000, 32'hDEAD_BEEF, 4'h3, 0, 1'b0, 0, "collide");
    single(1'b1, 1'b0, 32'h3000, 32'd0, 4'hF, 3, 1'b0, "waitld");
    single(1'b0, 1'b0, 32'h200, 32'd0, 4'hF, 0, 1'b1, "tmo");
    single(1'b0, 1'b0, 32'h204, 32'd0, 4'hF, TMO - 1, 1'b0, "lastready");
    single(1'b1, 1'b0, 32'h2000, 32'd0, 4'hF, 1, 1'b0, "rdback");
    single(1'b1, 1'b0, 32'h20, 32'd0, 4'hF, 0, 1'b1, "dtmo");

    // Reset during the second BUSY_D cycle abandons the load.
    drive_point();
    bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_addr = 32'h3000;
    bus.i_d_wdata = 32'h5555_AAAA; bus.i_d_byteen = 4'hF;
    drive_point();
    bus.i_mem_ready = 1'b0;
    drive_point();
    rst = 1'b1;
    drive_point();
    rst = 1'b0; bus.i_d_req = 1'b0; bus.i_mem_ready = 1'b1;
    bus.i_mem_read_data = 32'hBAD0_BAD0;
    exp_if_rdata = '0; exp_d_rdata = '0;
    @(negedge clk);
    chk_idle("midrst");
    chk("midrst_rdata", {bus.o_if_rdata, bus.o_d_rdata}, 64'd0);
    repeat (3) begin
      drive_point();
      @(negedge clk);
      chk_idle("lateready");
    end

    repeat (6) begin
      drive_point();
      bus.i_mem_ready = 1'($urandom);
      bus.i_mem_read_data = $urandom;
      @(negedge clk);
      chk_idle("noise");
    end

    for (int it = 0; it < 40; it++) begin
      mode = int'($urandom_range(0, 2));
      a  = {27'd0, 3'($urandom), 2'b00};
      w  = $urandom;
      be = 4'($urandom_range(1, 15));
      case (mode)
        0: single(1'b0, 1'b0, a, 32'd0, 4'hF, int'($urandom_range(0, 4)),
                  ($urandom_range(0, 7) == 0), "rnd_if");
        1: single(1'b1, 1'($urandom), a, w, be, int'($urandom_range(0, 4)),
                  ($urandom_range(0, 7) == 0), "rnd_d");
        default: collide({27'd0, 3'($urandom), 2'b00}, 1'($urandom), a, w, be,
                         int'($urandom_range(0, 4)), ($urandom_range(0, 7) == 0),
                         int'($urandom_range(0, 4)), "rnd_col");
      endcase
      repeat ($urandom_range(0, 2)) begin
        drive_point();
        bus.i_mem_ready = 1'($urandom);
        @(negedge clk);
        chk_idle("rnd_gap");
      end
      drive_point();
      bus.i_mem_ready = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the data/address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, ≥1: maximum BUSY cycles without i_mem_ready before a transfer is aborted.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_if_req, i_if_addr  in  1, WIDTH  instruction-fetch request and word address; held stable until o_if_valid.
REQ-006 o_if_rdata, o_if_valid, o_if_err  out  WIDTH, 1, 1  fetched word, one-cycle completion pulse, error flag.
REQ-007 i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_byteen  in  1, 1, WIDTH, WIDTH, 4  data request; all held stable until o_d_valid.
REQ-008 o_d_rdata, o_d_valid, o_d_err  out  WIDTH, 1, 1  load data, completion pulse, error flag.
REQ-009 o_mem_req, o_mem_addr, o_mem_write_data, o_mem_byteen, o_mem_write_enable, o_mem_read_enable  out  1, WIDTH, WIDTH, 4, 1, 1  shared memory bus.
REQ-010 i_mem_ready, i_mem_read_data  in  1, WIDTH  memory completion and read data; sampled only in BUSY states.
REQ-011 o_stall_if, o_stall_mem  out  1, 1  pipeline stall requests.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-013 In IDLE, an eligible i_d_req SHALL win; otherwise an eligible i_if_req wins; the grant latches the winner's address, wdata, byteen and we, and the FSM enters BUSY_D or BUSY_I on that edge.
REQ-014 A requester SHALL be ineligible in any cycle where its own valid output is high (prevents duplicate grant of a held request).
REQ-015 IF transfers SHALL latch byteen 4'hF, we 0, wdata 0.
REQ-016 In IDLE all bus outputs SHALL be 0.
REQ-017 In BUSY states o_mem_req=1 and the address, write_data and byteen outputs SHALL be driven only from latched registers, stable for the whole transfer.
REQ-018 In BUSY states o_mem_write_enable SHALL equal the latched we and o_mem_read_enable its inverse.
REQ-019 A wait counter SHALL clear on grant and increment each BUSY cycle without i_mem_ready.
REQ-020 In BUSY, i_mem_ready=1 SHALL complete the transfer on that edge: the owner's rdata is registered from i_mem_read_data (loads and fetches only; for writes o_d_rdata holds its prior value), valid=1 and err=0 for exactly the next cycle, and the FSM returns to IDLE.
REQ-021 If the TIMEOUT-th BUSY cycle has i_mem_ready=0, that edge SHALL abort the transfer: owner rdata=0, valid=1, err=1 for one cycle, FSM to IDLE.
REQ-022 i_mem_ready=1 in BUSY cycle TIMEOUT SHALL take precedence over abort.
REQ-023 i_mem_ready SHALL be ignored in IDLE.
REQ-024 Minimum latency: request seen in IDLE at cycle T, bus active at T+1, valid at T+2 with zero-wait memory; peak throughput is one transfer per 2 cycles.
REQ-025 o_stall_if = i_if_req & ~o_if_valid; o_stall_mem = i_d_req & ~o_d_valid; both combinational.
REQ-026 Simultaneous requests SHALL alternate naturally: a completed D request is masked in its valid cycle, so a waiting IF is granted then.

Reset
REQ-027 While i_reset=1, at the next edge FSM=IDLE, wait counter=0, all valid/err=0, rdata outputs=0, all latched payload=0; this holds regardless of the current state.
REQ-028 Reset mid-transfer SHALL abandon the transfer with no valid pulse; a late i_mem_ready after reset is ignored.

Verification
REQ-029 Fetch: i_if_req, addr 0x00000100; i_mem_ready=1 in first BUSY cycle with data 0x00000013 -> cycle T+1 o_mem_addr=0x100, byteen=F, re=1, we=0; T+2 o_if_valid=1, o_if_rdata=0x00000013, err=0; o_stall_if high T..T+1.
REQ-030 Collision: i_if_req (0x104) and D write (0x2000, 0xDEADBEEF, byteen 0x3) asserted same cycle -> D served first (we=1, re=0, byteen=0x3); IF granted in o_d_valid cycle; no duplicate D transfer.
REQ-031 Wait states: D load 0x3000, ready asserted after 3 BUSY cycles with 0x12345678 -> bus outputs unchanged across all 4 BUSY cycles; o_d_valid one cycle later, rdata 0x12345678.
REQ-032 Timeout: TIMEOUT=16, i_mem_ready never asserted -> exactly 16 BUSY cycles, then o_if_valid=1, o_if_err=1, o_if_rdata=0; ready at cycle 16 instead -> normal completion, err=0.
REQ-033 Reset mid-transfer: i_reset in 2nd BUSY_D cycle -> next cycle all bus outputs 0; i_mem_ready=1 afterwards produces no valid pulse.
REQ-034 Idle noise: i_mem_ready=1 with no requests -> no valid pulses, bus outputs remain 0.
